// File: rtl/ysyx_24100012_ifu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24100012_ifu_pkg
// Shared definitions for the instruction fetch unit:
//   - ifu_state_t   : fetch FSM state encoding
//   - NOP_INST      : instruction substituted for faulted fetches (addi x0,x0,0)
//   - IFU_RESET_PC  : default first fetch address after reset
// ----------------------------------------------------------------------------
package ysyx_24100012_ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_NPC  = 2'd3
    } ifu_state_t;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24100012_ifu_reg.sv
// ----------------------------------------------------------------------------
// ysyx_24100012_Reg
// Generic write-enabled register with synchronous active-high reset.
//   clk, rst   : clock / synchronous reset (reset wins over wen)
//   din, wen   : load value and load enable
//   dout       : registered value, RESET_VAL after reset
// ----------------------------------------------------------------------------
module ysyx_24100012_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wen,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_24100012_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_24100012_ifu
// Instruction fetch unit: request -> wait for response -> present to decoder
// -> wait for next PC from execute -> request again.
//
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   imem_req_valid/ready/addr         : fetch request to instruction memory
//   imem_resp_valid/data/err          : fetch response (err = access fault)
//   out_valid/ready/inst/pc/fault     : instruction handed to the decoder
//   npc_valid, npc                    : next PC from the execute stage
//
// Configuration macro:
//   YSYX_24100012_IFU_MISALIGN_EN - when defined, a PC with pc[1:0]!=0 is not
//   fetched; a faulted nop is presented to the decoder instead. When undefined
//   the low PC bits are ignored and the request goes out unchanged.
// ----------------------------------------------------------------------------
module ysyx_24100012_ifu
    import ysyx_24100012_ifu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic                  out_fault,
    input  logic                  npc_valid,
    input  logic [DATA_WIDTH-1:0] npc
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INST);

    ifu_state_t            state_reg;
    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] inst_reg;
    logic                  fault_reg;
    logic                  pc_wen;
    logic                  misaligned;

`ifdef YSYX_24100012_IFU_MISALIGN_EN
    assign misaligned = |pc_reg[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // The PC only moves when execute delivers a next PC, either in the same
    // cycle as the decoder handshake or later while parked in S_NPC.
    assign pc_wen = npc_valid &
                    (((state_reg == S_OUT) & out_ready) | (state_reg == S_NPC));

    ysyx_24100012_Reg #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .din  (npc),
        .wen  (pc_wen),
        .dout (pc_reg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_REQ;
            inst_reg  <= '0;
            fault_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                S_REQ: begin
                    if (misaligned) begin
                        // Never touch memory with a misaligned PC; report it
                        // to the decoder as a faulted nop.
                        inst_reg  <= NOP;
                        fault_reg <= 1'b1;
                        state_reg <= S_OUT;
                    end else if (imem_req_ready) begin
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        inst_reg  <= imem_resp_err ? NOP : imem_resp_data;
                        fault_reg <= imem_resp_err;
                        state_reg <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state_reg <= npc_valid ? S_REQ : S_NPC;
                    end
                end
                S_NPC: begin
                    if (npc_valid) begin
                        state_reg <= S_REQ;
                    end
                end
                default: state_reg <= S_REQ;
            endcase
        end
    end

    // The address and decoder-side outputs come straight from registers, so
    // they are inherently stable while waiting for the respective handshake.
    assign imem_req_valid = (state_reg == S_REQ) & ~misaligned;
    assign imem_req_addr  = pc_reg;
    assign out_valid      = (state_reg == S_OUT);
    assign out_inst       = inst_reg;
    assign out_pc         = pc_reg;
    assign out_fault      = fault_reg;

endmodule

// File: tb/tb_ysyx_24100012_ifu.sv
module tb_ysyx_24100012_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef YSYX_24100012_IFU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        npc_valid;
    logic [31:0] npc;

    int total = 0;
    int bad   = 0;

    // Reference model state: the PC the next fetch must use.
    logic [31:0] exp_pc;

    ysyx_24100012_ifu #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h8000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .out_fault       (out_fault),
        .npc_valid       (npc_valid),
        .npc             (npc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Garbage npc traffic that the DUT must ignore in the current state.
    task automatic noise_npc();
        npc_valid = 1'($urandom_range(0, 1));
        npc       = $urandom;
    endtask

    // One complete instruction, from request to next-PC delivery.
    // d: cycles with req_ready low, lat: response latency (>=1),
    // w: cycles with out_ready low, z: S_NPC cycles before npc arrives,
    // same: npc delivered together with the decoder handshake.
    task automatic do_txn(input int d, input int lat, input int w, input int z,
                          input bit same, input bit err,
                          input logic [31:0] data, input logic [31:0] nxt);
        logic [31:0] exp_inst;
        logic        exp_fault;
        bit          mis;
        mis = MIS_EN && (exp_pc[1:0] != 2'b00);
        if (!mis) begin
            for (int i = 0; i < d; i++) begin
                check("req_valid_hold", 32'(imem_req_valid), 32'd1);
                check("req_addr_hold", imem_req_addr, exp_pc);
                check("out_valid_in_req", 32'(out_valid), 32'd0);
                imem_req_ready  = 1'b0;
                imem_resp_valid = 1'($urandom_range(0, 1));
                noise_npc();
                step();
            end
            check("req_valid", 32'(imem_req_valid), 32'd1);
            check("req_addr", imem_req_addr, exp_pc);
            imem_req_ready  = 1'b1;
            imem_resp_valid = 1'($urandom_range(0, 1));
            noise_npc();
            step();
            imem_req_ready  = 1'b0;
            imem_resp_valid = 1'b0;
            for (int i = 0; i < lat - 1; i++) begin
                check("req_valid_in_wait", 32'(imem_req_valid), 32'd0);
                check("out_valid_in_wait", 32'(out_valid), 32'd0);
                noise_npc();
                step();
            end
            check("out_valid_before_resp", 32'(out_valid), 32'd0);
            imem_resp_valid = 1'b1;
            imem_resp_data  = data;
            imem_resp_err   = err;
            noise_npc();
            step();
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'($urandom_range(0, 1));
            exp_inst  = err ? NOP : data;
            exp_fault = err;
        end else begin
            check("misalign_no_req", 32'(imem_req_valid), 32'd0);
            imem_req_ready = 1'($urandom_range(0, 1));
            noise_npc();
            step();
            imem_req_ready = 1'b0;
            exp_inst  = NOP;
            exp_fault = 1'b1;
        end
        for (int i = 0; i <= w; i++) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_inst", out_inst, exp_inst);
            check("out_pc", out_pc, exp_pc);
            check("out_fault", 32'(out_fault), 32'(exp_fault));
            check("req_valid_in_out", 32'(imem_req_valid), 32'd0);
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_resp_data  = $urandom;
            if (i < w) begin
                out_ready = 1'b0;
                noise_npc();
                step();
            end
        end
        out_ready = 1'b1;
        if (same) begin
            npc_valid = 1'b1;
            npc       = nxt;
            step();
        end else begin
            npc_valid = 1'b0;
            step();
            out_ready = 1'b0;
            for (int i = 0; i < z; i++) begin
                check("out_valid_in_npc", 32'(out_valid), 32'd0);
                check("req_valid_in_npc", 32'(imem_req_valid), 32'd0);
                imem_resp_valid = 1'($urandom_range(0, 1));
                step();
            end
            npc_valid = 1'b1;
            npc       = nxt;
            step();
        end
        out_ready       = 1'b0;
        npc_valid       = 1'b0;
        imem_resp_valid = 1'b0;
        $display("txn pc=%08h inst=%08h fault=%0d next=%08h", exp_pc, exp_inst, exp_fault, nxt);
        exp_pc = nxt;
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        out_ready       = 1'b0;
        npc_valid       = 1'b0;
        npc             = '0;
        exp_pc          = RST_PC;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_fault", 32'(out_fault), 32'd0);
        check("rst_out_pc", out_pc, RST_PC);
        check("rst_out_inst", out_inst, 32'd0);
        rst = 1'b0;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RST_PC);

        // Best-case first fetch, decoder stall of 5 cycles, same-cycle npc.
        do_txn(0, 1, 5, 0, 1'b1, 1'b0, 32'h0010_0093, 32'h8000_0010);
        // Errored fetch, late npc through S_NPC.
        do_txn(1, 3, 0, 2, 1'b0, 1'b1, 32'hdead_beef, 32'h8000_0004);

        // Reset while a response is outstanding; the late response is dropped.
        check("pre_rst_req", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_req_addr", imem_req_addr, RST_PC);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hcafe_f00d;
        step();
        imem_resp_valid = 1'b0;
        check("late_resp_req_valid", 32'(imem_req_valid), 32'd1);
        check("late_resp_out_valid", 32'(out_valid), 32'd0);
        check("late_resp_out_inst", out_inst, 32'd0);
        check("late_resp_out_fault", 32'(out_fault), 32'd0);
        exp_pc = RST_PC;

        // Misaligned next PC (faulted nop when the misalign check is built in).
        do_txn(0, 1, 0, 0, 1'b1, 1'b0, 32'h0020_0113, 32'h8000_0002);
        do_txn(0, 2, 1, 1, 1'b0, 1'b0, 32'h0030_0193, 32'h8000_0008);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] nxt;
            nxt = {16'h8000, 14'($urandom), 2'b00};
            if ($urandom_range(0, 7) == 0) nxt[1:0] = 2'($urandom_range(1, 3));
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                   $urandom, nxt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
